// File: rtl/erm16_bus_bridge.sv
// ERM16 bus bridge: handshaked external memory access with wait/timeout,
// plus a small I/O space (output port, input port, status register).
module erm16_bus_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wrmem,
  input  logic              cpu_ioe,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  output logic              cpu_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe,
  input  logic [DATA_W-1:0] io_in,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IO,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              acc_we;
  logic [DATA_W-1:0] io_rd;

  // I/O read decode; only the two low address bits select a register
  always_comb begin
    io_rd = '0;
    unique case (mem_addr[1:0])
      2'd0:    io_rd = io_in;
      2'd1:    io_rd = {{(DATA_W-1){1'b0}}, bus_err};
      default: io_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_we    <= 1'b0;
      cpu_rdata <= '0;
      cpu_hold  <= 1'b0;
      cpu_done  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      io_out    <= '0;
      io_strobe <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cpu_done  <= 1'b0;
      io_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            acc_we    <= cpu_wrmem;
            cpu_hold  <= 1'b1;
            if (cpu_ioe) begin
              state <= IO;
            end else begin
              state   <= MEM_WAIT;
              mem_req <= 1'b1;
              mem_we  <= cpu_wrmem;
              cnt     <= '0;
            end
          end
        end
        MEM_WAIT: begin
          // an ack on the last allowed cycle still completes normally
          if (mem_ack) begin
            if (!acc_we) cpu_rdata <= mem_rdata;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            cpu_hold <= 1'b0;
            cpu_done <= 1'b1;
            state    <= DONE;
          end else if (cnt == TO_LAST) begin
            cpu_rdata <= '1;
            bus_err   <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            cpu_done  <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IO: begin
          if (acc_we) begin
            if (mem_addr[1:0] == 2'd0) begin
              io_out    <= mem_wdata;
              io_strobe <= 1'b1;
            end else if (mem_addr[1:0] == 2'd1 && mem_wdata[0]) begin
              bus_err <= 1'b0;
            end
          end else begin
            cpu_rdata <= io_rd;
          end
          cpu_hold <= 1'b0;
          cpu_done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
